qpsk_p2s: RTL



---
 rtl/qpsk_p2s.sv | 137 +++++++++++++
 1 files changed

// File: rtl/qpsk_p2s.sv
// Re-serialises buffered QPSK (I, Q) symbol pairs into a BIT_DIV-cycle-per-bit stream.
// Latency 1..BIT_DIV cycles from push to first bit; sym_ready drops when the FIFO is full and extra symbols are dropped with a sticky overflow.
module qpsk_p2s #(
    parameter int BIT_DIV    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int I_FIRST    = 1
) (
    input  logic clk_8megahz,
    input  logic rst,
    input  logic sym_valid,
    input  logic sym_i,
    input  logic sym_q,
    output logic sym_ready,
    output logic binary_data,
    output logic bit_valid,
    output logic bit_strobe,
    output logic overflow,
    output logic underrun
);

    localparam int CNTW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = PW + 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FIRST  = 2'd1;
    localparam logic [1:0] S_SECOND = 2'd2;

    logic [CNTW-1:0] cnt;
    logic            bit_end;
    logic [1:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic [1:0]      head;
    logic            head_first;
    logic            head_second;
    logic [1:0]      state;
    logic            second_bit;

    assign bit_end     = (cnt == CNTW'(BIT_DIV - 1));
    assign sym_ready   = (count < CW'(FIFO_DEPTH));
    assign fifo_empty  = (count == '0);
    assign push        = sym_valid && sym_ready;
    assign pop         = bit_end && !fifo_empty && (state != S_FIRST);
    assign head        = mem[rd_ptr];
    assign head_first  = (I_FIRST != 0) ? head[1] : head[0];
    assign head_second = (I_FIRST != 0) ? head[0] : head[1];

    // Free-running bit timer; never gated so the bit grid stays fixed.
    always_ff @(posedge clk_8megahz) begin
        if (rst) begin
            cnt <= '0;
        end else if (bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNTW'(1);
        end
    end

    always_ff @(posedge clk_8megahz) begin
        if (push) begin
            mem[wr_ptr] <= {sym_i, sym_q};
        end
    end

    always_ff @(posedge clk_8megahz) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_8megahz) begin
        if (rst) begin
            state       <= S_IDLE;
            second_bit  <= 1'b0;
            binary_data <= 1'b0;
            bit_valid   <= 1'b0;
            bit_strobe  <= 1'b0;
            overflow    <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            bit_strobe <= 1'b0;
            underrun   <= 1'b0;
            if (sym_valid && !sym_ready) begin
                overflow <= 1'b1;
            end
            if (bit_end) begin
                case (state)
                    S_FIRST: begin
                        state       <= S_SECOND;
                        binary_data <= second_bit;
                        bit_strobe  <= 1'b1;
                    end
                    S_IDLE, S_SECOND: begin
                        if (!fifo_empty) begin
                            state       <= S_FIRST;
                            binary_data <= head_first;
                            second_bit  <= head_second;
                            bit_valid   <= 1'b1;
                            bit_strobe  <= 1'b1;
                        end else begin
                            // Leaving SECOND with nothing queued ends the stream.
                            underrun    <= (state == S_SECOND);
                            state       <= S_IDLE;
                            binary_data <= 1'b0;
                            bit_valid   <= 1'b0;
                        end
                    end
                    default: begin
                        state       <= S_IDLE;
                        binary_data <= 1'b0;
                        bit_valid   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
